// File: rtl/softmax_argmax.sv
// softmax_argmax: top-1 classifier stage that sits after softmax_core.
// It scans DATA_SIZE binary32 probabilities from the shared result memory
// and returns the index and raw bits of the largest entry over a
// valid/ready handshake. argmax_done pulses for one cycle once the result
// has been accepted.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   argmax_start  single-cycle start pulse, honoured only in IDLE
//   argmax_done   one-cycle pulse after the result is accepted
//   busy          high in every state except IDLE
//   rd_addr       result memory read address
//   data_in       read data, RD_LATENCY cycles after rd_addr
//   result_valid  result available, held until result_ready
//   result_ready  downstream accepts the result
//   result_idx    index of the maximum entry
//   result_val    raw bit pattern of the maximum entry
//   result_nan    every scanned entry was NaN
module softmax_argmax #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int DATA_SIZE  = 128,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          argmax_start,
  output logic          argmax_done,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] data_in,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [AW-1:0] result_idx,
  output logic [DW-1:0] result_val,
  output logic          result_nan
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_SIZE - 1);
  localparam logic [DW-1:0] QNAN      = 32'h7FC0_0000;

  state_t          state;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [RD_LATENCY-1:0] last_sr;
  logic [AW-1:0]   idx_sr [RD_LATENCY];

  logic            have_best;
  logic [DW-1:0]   best_val;
  logic [AW-1:0]   best_idx;

  logic            issue;
  logic            issue_last;
  logic            ret_valid;
  logic            ret_last;
  logic [AW-1:0]   ret_idx;
  logic            ret_nan;
  logic            take;
  logic            nxt_have;
  logic [DW-1:0]   nxt_val;
  logic [AW-1:0]   nxt_idx;

  // Map a float onto an unsigned key whose ordering matches numeric order:
  // negatives are bit-inverted, positives get their sign bit flipped, so
  // -0.0 lands just below +0.0.
  function automatic logic [DW-1:0] to_key(input logic [DW-1:0] x);
    return x[DW-1] ? ~x : (x ^ {1'b1, {(DW-1){1'b0}}});
  endfunction

  assign busy       = (state != IDLE);
  assign issue      = (state == READ);
  assign issue_last = issue && (rd_addr == LAST_ADDR);

  assign ret_valid  = vld_sr[RD_LATENCY-1];
  assign ret_last   = last_sr[RD_LATENCY-1];
  assign ret_idx    = idx_sr[RD_LATENCY-1];

  // Running maximum including the datum returning this cycle. The final
  // return feeds the result registers directly so that result_valid rises
  // on the same edge as the last comparison.
  assign ret_nan  = (data_in[30:23] == 8'hFF) && (data_in[22:0] != 23'd0);
  assign take     = ret_valid && !ret_nan &&
                    (!have_best || (to_key(data_in) > to_key(best_val)));
  assign nxt_have = have_best | take;
  assign nxt_val  = take ? data_in : best_val;
  assign nxt_idx  = take ? ret_idx : best_idx;

  // In-flight tracking: one stage per cycle of memory latency, so the tail
  // stage lines up with the datum on data_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue_last;
      idx_sr[0]  <= rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
        idx_sr[i]  <= idx_sr[i-1];
      end
    end
  end

  // Control FSM with the best-so-far and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr      <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_val   <= '0;
      result_nan   <= 1'b0;
      argmax_done  <= 1'b0;
      have_best    <= 1'b0;
      best_val     <= '0;
      best_idx     <= '0;
    end else begin
      argmax_done <= 1'b0;
      case (state)
        IDLE: begin
          rd_addr <= '0;
          if (argmax_start) begin
            have_best <= 1'b0;
            best_val  <= '0;
            best_idx  <= '0;
            state     <= READ;
          end
        end
        READ: begin
          have_best <= nxt_have;
          best_val  <= nxt_val;
          best_idx  <= nxt_idx;
          if (rd_addr == LAST_ADDR) begin
            rd_addr <= '0;
            state   <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          have_best <= nxt_have;
          best_val  <= nxt_val;
          best_idx  <= nxt_idx;
          if (ret_valid && ret_last) begin
            result_valid <= 1'b1;
            state        <= OUT;
            if (nxt_have) begin
              result_idx <= nxt_idx;
              result_val <= nxt_val;
              result_nan <= 1'b0;
            end else begin
              result_idx <= '0;
              result_val <= QNAN;
              result_nan <= 1'b1;
            end
          end
        end
        OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            argmax_done  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
